rps_remote_player: RTL and testbench

Automated opponent for the iCEBreaker rock-paper-scissors game board, running on a second board cabled PMOD-to-PMOD. It presses one of the game's three active-low choice lines and holds it. While the line is held it reads back the game's 3-bit score bus and classifies the round as win, loss, tie or error. It also keeps saturating tallies for a status/LED wrapper.

---
 rtl/rps_remote_player.sv | 251 +++++++++++++++++++++++++
 tb/tb_rps_remote_player.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rps_remote_player.sv
`default_nettype none
// ============================================================================
//  Module      : rps_remote_player
//  Description : Automated rock-paper-scissors opponent. Presses one of the
//                game's active-low choice lines for a fixed hold window,
//                watches the synchronized score bus for a stable code,
//                classifies the round and keeps saturating tallies.
//                Optional feature macro: RPS_LFSR_EN (random choice when
//                choice == 0, driven by a 16-bit Fibonacci LFSR).
//  Revision    : 1.0 - initial release
// ============================================================================
module rps_remote_player #(
    parameter int HOLD_CYCLES   = 1200000,
    parameter int SETTLE_CYCLES = 8,
    parameter int STABLE_CYCLES = 16,
    parameter int GAP_CYCLES    = 2400000,
    parameter int CNT_W         = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic [1:0]       choice,
    output logic [2:0]       choice_n,
    input  logic [2:0]       score_in,
    output logic             busy,
    output logic             result_valid,
    output logic [1:0]       result,
    output logic [CNT_W-1:0] wins,
    output logic [CNT_W-1:0] losses,
    output logic [CNT_W-1:0] ties,
    output logic [CNT_W-1:0] errors
);

    // Shared timer covers both the hold and the gap windows.
    localparam int c_TMR_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int c_TMR_W   = $clog2(c_TMR_MAX + 1);
    localparam int c_STB_W   = $clog2(STABLE_CYCLES + 1);

    localparam logic [c_TMR_W-1:0] c_HOLD_LAST = c_TMR_W'(HOLD_CYCLES - 1);
    localparam logic [c_TMR_W-1:0] c_GAP_LAST  = c_TMR_W'(GAP_CYCLES - 1);
    localparam logic [c_TMR_W-1:0] c_SETTLE    = c_TMR_W'(SETTLE_CYCLES);
    localparam logic [c_STB_W-1:0] c_STABLE    = c_STB_W'(STABLE_CYCLES);
    localparam logic [c_STB_W-1:0] c_STB_ONE   = c_STB_W'(1);
    localparam logic [CNT_W-1:0]   c_CNT_MAX   = {CNT_W{1'b1}};

    // Game score codes seen while a choice line is held.
    localparam logic [2:0] c_SCORE_WIN  = 3'b001;
    localparam logic [2:0] c_SCORE_LOSS = 3'b010;
    localparam logic [2:0] c_SCORE_TIE  = 3'b100;

    // Round result encoding.
    localparam logic [1:0] c_RES_ERR  = 2'd0;
    localparam logic [1:0] c_RES_WIN  = 2'd1;
    localparam logic [1:0] c_RES_LOSS = 2'd2;
    localparam logic [1:0] c_RES_TIE  = 2'd3;

    // FSM encoding.
    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_PRESS   = 2'd1;
    localparam logic [1:0] c_ST_RELEASE = 2'd2;

    logic [1:0]         r_state;
    logic [c_TMR_W-1:0] r_tmr;
    logic [c_STB_W-1:0] r_stab;
    logic [2:0]         r_sync1;
    logic [2:0]         r_s;
    logic [2:0]         r_s_prev;
    logic               r_start_q;
    logic [1:0]         r_choice;
    logic               r_result_valid;
    logic [1:0]         r_result;
    logic [CNT_W-1:0]   r_wins;
    logic [CNT_W-1:0]   r_losses;
    logic [CNT_W-1:0]   r_ties;
    logic [CNT_W-1:0]   r_errors;

    logic [1:0]         w_next_state;
    logic [c_TMR_W-1:0] w_tmr_next;
    logic [c_STB_W-1:0] w_stab_next;
    logic               w_start_rise;
    logic [1:0]         w_eff_choice;
    logic               w_launch;
    logic               w_finish;
    logic [1:0]         w_cls_result;

    assign w_start_rise = start & ~r_start_q;

`ifdef RPS_LFSR_EN
    logic [15:0] r_lfsr;
    logic        w_lfsr_fb;

    // Taps 16,14,13,11 in 1-based numbering.
    assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

    // Free-running LFSR, advanced every cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_lfsr <= 16'hACE1;
        end else begin
            r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
        end
    end

    // Choice 0 picks from the LFSR; a zero draw falls back to rock.
    always_comb begin
        w_eff_choice = choice;
        if (choice == 2'd0) begin
            w_eff_choice = (r_lfsr[1:0] == 2'd0) ? 2'd1 : r_lfsr[1:0];
        end
    end
`else
    // Without the LFSR a choice of 0 stays 0 and the start edge is ignored.
    always_comb begin
        w_eff_choice = choice;
    end
`endif

    // Classification of the synchronized score against the stability gate.
    always_comb begin
        w_cls_result = c_RES_ERR;
        if (r_stab == c_STABLE) begin
            case (r_s)
                c_SCORE_WIN:  w_cls_result = c_RES_WIN;
                c_SCORE_LOSS: w_cls_result = c_RES_LOSS;
                c_SCORE_TIE:  w_cls_result = c_RES_TIE;
                default:      w_cls_result = c_RES_ERR;
            endcase
        end
    end

    // Next-state, timer and stability-counter logic.
    always_comb begin
        w_next_state = r_state;
        w_tmr_next   = r_tmr;
        w_stab_next  = r_stab;
        w_launch     = 1'b0;
        w_finish     = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                w_tmr_next = '0;
                if (w_start_rise && (w_eff_choice != 2'd0)) begin
                    w_next_state = c_ST_PRESS;
                    w_launch     = 1'b1;
                    w_stab_next  = '0;
                end
            end
            c_ST_PRESS: begin
                if (r_tmr == c_HOLD_LAST) begin
                    w_next_state = c_ST_RELEASE;
                    w_tmr_next   = '0;
                    w_finish     = 1'b1;
                end else begin
                    w_tmr_next = r_tmr + 1'b1;
                end
                // Early samples are skipped to let the synchronizer and the
                // game's own latching catch up with the press.
                if (r_tmr >= c_SETTLE) begin
                    if (r_s == r_s_prev) begin
                        w_stab_next = (r_stab == c_STABLE) ? r_stab : r_stab + 1'b1;
                    end else begin
                        w_stab_next = c_STB_ONE;
                    end
                end
            end
            c_ST_RELEASE: begin
                if (r_tmr == c_GAP_LAST) begin
                    w_next_state = c_ST_IDLE;
                    w_tmr_next   = '0;
                end else begin
                    w_tmr_next = r_tmr + 1'b1;
                end
            end
            default: begin
                w_next_state = c_ST_IDLE;
                w_tmr_next   = '0;
            end
        endcase
    end

    // Choice line and busy decode from the current state.
    always_comb begin
        choice_n = 3'b111;
        if (r_state == c_ST_PRESS) begin
            case (r_choice)
                2'd1:    choice_n = 3'b110;
                2'd2:    choice_n = 3'b101;
                2'd3:    choice_n = 3'b011;
                default: choice_n = 3'b111;
            endcase
        end
    end

    assign busy = (r_state != c_ST_IDLE);

    // State, timers, synchronizer and start-edge registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= c_ST_IDLE;
            r_tmr     <= '0;
            r_stab    <= '0;
            r_sync1   <= '0;
            r_s       <= '0;
            r_s_prev  <= '0;
            r_start_q <= 1'b0;
            r_choice  <= 2'd0;
        end else begin
            r_state   <= w_next_state;
            r_tmr     <= w_tmr_next;
            r_stab    <= w_stab_next;
            r_sync1   <= score_in;
            r_s       <= r_sync1;
            r_s_prev  <= r_s;
            r_start_q <= start;
            if (w_launch) begin
                r_choice <= w_eff_choice;
            end
        end
    end

    // Result pulse and saturating tallies, updated as PRESS ends.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_result_valid <= 1'b0;
            r_result       <= c_RES_ERR;
            r_wins         <= '0;
            r_losses       <= '0;
            r_ties         <= '0;
            r_errors       <= '0;
        end else begin
            r_result_valid <= w_finish;
            if (w_finish) begin
                r_result <= w_cls_result;
                case (w_cls_result)
                    c_RES_WIN:  r_wins   <= (r_wins   == c_CNT_MAX) ? r_wins   : r_wins   + 1'b1;
                    c_RES_LOSS: r_losses <= (r_losses == c_CNT_MAX) ? r_losses : r_losses + 1'b1;
                    c_RES_TIE:  r_ties   <= (r_ties   == c_CNT_MAX) ? r_ties   : r_ties   + 1'b1;
                    default:    r_errors <= (r_errors == c_CNT_MAX) ? r_errors : r_errors + 1'b1;
                endcase
            end
        end
    end

    assign result_valid = r_result_valid;
    assign result       = r_result;
    assign wins         = r_wins;
    assign losses       = r_losses;
    assign ties         = r_ties;
    assign errors       = r_errors;

endmodule
`default_nettype wire

// File: tb/tb_rps_remote_player.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rps_remote_player
//  Description : Scoreboard bench for rps_remote_player with randomized rounds
//                and a rule-level reference model of round outcomes/tallies.
//                Honors RPS_LFSR_EN for the random-choice round.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rps_remote_player;

    localparam int c_HOLD   = 64;
    localparam int c_SETTLE = 4;
    localparam int c_STABLE = 8;
    localparam int c_GAP    = 16;
    localparam int c_CNT_W  = 4;
    localparam int c_SAT    = 15;

    logic                CLK = 1'b0;
    logic                RST;
    logic                start;
    logic [1:0]          choice;
    logic [2:0]          choice_n;
    logic [2:0]          score_in;
    logic                busy;
    logic                result_valid;
    logic [1:0]          result;
    logic [c_CNT_W-1:0]  wins;
    logic [c_CNT_W-1:0]  losses;
    logic [c_CNT_W-1:0]  ties;
    logic [c_CNT_W-1:0]  errors;

    rps_remote_player #(
        .HOLD_CYCLES   (c_HOLD),
        .SETTLE_CYCLES (c_SETTLE),
        .STABLE_CYCLES (c_STABLE),
        .GAP_CYCLES    (c_GAP),
        .CNT_W         (c_CNT_W)
    ) u_dut (
        .CLK          (CLK),
        .RST          (RST),
        .start        (start),
        .choice       (choice),
        .choice_n     (choice_n),
        .score_in     (score_in),
        .busy         (busy),
        .result_valid (result_valid),
        .result       (result),
        .wins         (wins),
        .losses       (losses),
        .ties         (ties),
        .errors       (errors)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int res;
        int w;
        int l;
        int t;
        int e;
    } exp_t;

    exp_t       exp_q[$];
    logic [2:0] ch_q[$];

    int n_vec = 0;
    int n_err = 0;

    // Reference tallies
    int m_w = 0, m_l = 0, m_t = 0, m_e = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int sat_inc(input int v);
        return (v < c_SAT) ? v + 1 : c_SAT;
    endfunction

    // Score bus pattern during a round, indexed by cycles since the press.
    function automatic logic [2:0] pat_val(input int pat, input int i);
        case (pat)
            0:       return 3'd1;
            1:       return 3'd2;
            2:       return 3'd4;
            3:       return (((i / 2) % 2) != 0) ? 3'd3 : 3'd4;
            4:       return 3'd3;
            5:       return 3'd0;
            6:       return (i < 20) ? 3'd1 : 3'd4;
            default: return 3'd3;
        endcase
    endfunction

    // Game rule: a code that is steady at the end of the hold is classified,
    // a toggling bus or a non-result code is an error.
    function automatic int expected_result(input int pat);
        logic [2:0] fin;
        fin = pat_val(pat, c_HOLD - 1);
        if (pat == 3) return 0;
        case (fin)
            3'd1:    return 1;
            3'd2:    return 2;
            3'd4:    return 3;
            default: return 0;
        endcase
    endfunction

    task automatic model_round(input int pat);
        exp_t e;
        e.res = expected_result(pat);
        case (e.res)
            1:       m_w = sat_inc(m_w);
            2:       m_l = sat_inc(m_l);
            3:       m_t = sat_inc(m_t);
            default: m_e = sat_inc(m_e);
        endcase
        e.w = m_w; e.l = m_l; e.t = m_t; e.e = m_e;
        exp_q.push_back(e);
    endtask

    // Called right after a rising clock edge (+1).
    task automatic run_round(input int ch, input int pat, input bit dbl_start, input bit rst_mid);
        int k;
        if (!rst_mid) model_round(pat);
        ch_q.push_back((ch == 0) ? 3'b000 : ~(3'b001 << (ch - 1)));
        choice = 2'(ch);
        start  = 1'b1;
        for (int i = 0; i < 70; i++) begin
            score_in = pat_val(pat, i);
            @(posedge CLK); #1;
            if (i == 0) check("busy_rise", busy, 1);
            if (i == 3) start = 1'b0;
            if (dbl_start && i == 10) start = 1'b1;
            if (dbl_start && i == 12) start = 1'b0;
            if (rst_mid && i == 30) begin
                RST = 1'b1;
                @(posedge CLK); #1;
                RST = 1'b0;
                check("rst_choice_n", choice_n, 3'b111);
                check("rst_busy", busy, 0);
                check("rst_wins", wins, 0);
                check("rst_losses", losses, 0);
                check("rst_ties", ties, 0);
                check("rst_errors", errors, 0);
                m_w = 0; m_l = 0; m_t = 0; m_e = 0;
                score_in = 3'd3;
                repeat (4) begin @(posedge CLK); #1; end
                return;
            end
        end
        score_in = 3'd3;
        k = 0;
        while (busy && k < 100) begin
            @(posedge CLK); #1;
            k++;
        end
        check("round_done_in_time", busy, 0);
        @(posedge CLK); #1;
    endtask

    // Monitor: pops expectations whenever the DUT presents a choice or result.
    logic [2:0] prev_cn;
    int         hold_cnt, gap_cnt;
    bit         in_hold, in_gap;

    initial begin
        exp_t       e;
        logic [2:0] ech;
        prev_cn = 3'b111;
        in_hold = 1'b0;
        in_gap  = 1'b0;
        hold_cnt = 0;
        gap_cnt  = 0;
        forever begin
            @(negedge CLK);
            if (RST) begin
                in_hold = 1'b0;
                in_gap  = 1'b0;
                prev_cn = 3'b111;
            end else begin
                if (result_valid) begin
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_result_valid: got result %0d, expected no pulse (t=%0t)", result, $time);
                    end else begin
                        e = exp_q.pop_front();
                        check("result", result, e.res);
                        check("wins", wins, e.w);
                        check("losses", losses, e.l);
                        check("ties", ties, e.t);
                        check("errors", errors, e.e);
                    end
                end
                if (prev_cn == 3'b111 && choice_n != 3'b111) begin
                    in_hold  = 1'b1;
                    hold_cnt = 0;
                    if (ch_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_press: got choice_n %b, expected 111 (t=%0t)", choice_n, $time);
                    end else begin
                        ech = ch_q.pop_front();
                        if (ech == 3'b000)
                            check("choice_n_onehot_low", $countones(~choice_n), 1);
                        else
                            check("choice_n", choice_n, ech);
                    end
                end
                if (in_hold) begin
                    if (choice_n != 3'b111) begin
                        hold_cnt++;
                    end else begin
                        in_hold = 1'b0;
                        check("hold_cycles", hold_cnt, c_HOLD);
                        check("valid_at_release", result_valid, 1);
                        in_gap  = 1'b1;
                        gap_cnt = 0;
                    end
                end
                if (in_gap) begin
                    if (busy) begin
                        gap_cnt++;
                    end else begin
                        in_gap = 1'b0;
                        check("gap_cycles", gap_cnt, c_GAP);
                    end
                end
                prev_cn = choice_n;
            end
        end
    end

    initial begin
        RST      = 1'b1;
        start    = 1'b0;
        choice   = 2'd0;
        score_in = 3'd3;
        repeat (3) @(posedge CLK);
        #1;
        check("reset_choice_n", choice_n, 3'b111);
        check("reset_busy", busy, 0);
        check("reset_result_valid", result_valid, 0);
        check("reset_result", result, 0);
        check("reset_wins", wins, 0);
        check("reset_errors", errors, 0);
        RST = 1'b0;
        repeat (2) begin @(posedge CLK); #1; end

        run_round(1, 0, 1'b0, 1'b0);   // rock, player wins
        run_round(3, 2, 1'b0, 1'b0);   // scissors, tie
        run_round(2, 3, 1'b0, 1'b0);   // paper, toggling score -> error

        for (int r = 0; r < 20; r++)   // wins saturates; extra start edge in PRESS
            run_round(1, 0, (r == 0), 1'b0);

        for (int r = 0; r < 12; r++)
            run_round(int'($urandom_range(1, 3)), int'($urandom_range(0, 6)),
                      bit'($urandom_range(0, 1)), 1'b0);

        run_round(2, 0, 1'b0, 1'b1);   // reset mid-press

`ifdef RPS_LFSR_EN
        run_round(0, 1, 1'b0, 1'b0);
`else
        choice = 2'd0;
        start  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge CLK); #1;
            if (i % 5 == 0) begin
                check("choice0_busy", busy, 0);
                check("choice0_choice_n", choice_n, 3'b111);
            end
        end
        start = 1'b0;
        repeat (2) begin @(posedge CLK); #1; end
`endif

        run_round(3, 1, 1'b0, 1'b0);   // after reset: loss from zero tallies

        repeat (4) begin @(posedge CLK); #1; end
        check("scoreboard_drained", exp_q.size(), 0);
        check("choice_queue_drained", ch_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
